// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// Contents: sequencer state enum, relock counter width, constant max helper.
// Used by the interface and by the sequencer top.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int RELOCK_W = 8;

  // Largest of three timing parameters; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the sequencer and the PLL / subsystem.
// Signals: locked (from PLL), pll_rst, reset_out, ready, relock_count, timeout_err.
// master = sequencer side, slave = PLL/subsystem side.
interface pll_reset_sequencer_if;
  import pll_reset_sequencer_pkg::*;

  logic                locked;
  logic                pll_rst;
  logic                reset_out;
  logic                ready;
  logic [RELOCK_W-1:0] relock_count;
  logic                timeout_err;

  modport master (
    input  locked,
    output pll_rst, reset_out, ready, relock_count, timeout_err
  );

  modport slave (
    output locked,
    input  pll_rst, reset_out, ready, relock_count, timeout_err
  );

endinterface

// File: rtl/pll_reset_sequencer_bit_sync_2ff.sv
// Two-flop synchroniser for a single slow asynchronous level.
// Latency: input change visible on q after the second clk edge.
// Ports: clk, rst (async active-high, clears both flops), d (async), q (synchronised).
module bit_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generator and lock qualifier; holds the subsystem in reset until lock is stable.
// Latency: locked -> state change 3 refclk edges; all outputs registered, same edge as the state.
// Ports: refclk, rst (async active-high), seq (master: locked in; pll_rst/reset_out/ready/relock_count/timeout_err out).
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 10,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master seq
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));

  localparam logic [CNT_W-1:0] RST_TC = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic                locked_s;
  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                armed;
  logic                tmo_ev, relock_ev;

  logic                pll_rst_q, reset_out_q, ready_q, timeout_err_q;
  logic [RELOCK_W-1:0] relock_count_q;

  bit_sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (seq.locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    tmo_ev    = 1'b0;
    relock_ev = 1'b0;
    case (state)
      PLL_RESET: begin
        if (cnt == RST_TC) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock wins over timeout on the terminal-count cycle.
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TMO_TC) begin
          state_nxt = PLL_RESET;
          cnt_nxt   = '0;
          tmo_ev    = 1'b1;
        end
      end
      STABLE: begin
        // A dropout here only restarts the lock wait; the PLL is not re-pulsed.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STB_TC) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = PLL_RESET;
          relock_ev = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RESET;
        cnt_nxt   = '0;
      end
    endcase
    // rst release is asynchronous: the first edge afterwards only arms the
    // FSM, so the first pll_rst pulse is a full PLL_RST_CYCLES edges.
    if (!armed) begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_ev    = 1'b0;
      relock_ev = 1'b0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state          <= PLL_RESET;
      cnt            <= '0;
      armed          <= 1'b0;
      pll_rst_q      <= 1'b1;
      reset_out_q    <= 1'b1;
      ready_q        <= 1'b0;
      relock_count_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      armed       <= 1'b1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pll_rst_q   <= (state_nxt == PLL_RESET);
      reset_out_q <= (state_nxt != RUN);
      ready_q     <= (state_nxt == RUN);
      if (tmo_ev) begin
        timeout_err_q <= 1'b1;
      end
      if (relock_ev && (relock_count_q != '1)) begin
        relock_count_q <= relock_count_q + 1'b1;
      end
    end
  end

  assign seq.pll_rst      = pll_rst_q;
  assign seq.reset_out    = reset_out_q;
  assign seq.ready        = ready_q;
  assign seq.relock_count = relock_count_q;
  assign seq.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=100.
// Stimulus pushes every expected output change (cycle, value) into a queue;
// a monitor compares each observed output change against the queue head.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  // Output vector layout: {pll_rst, reset_out, ready, timeout_err, relock_count[7:0]}
  localparam logic [11:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

  typedef struct {
    int          cyc;
    logic [11:0] vec;
  } exp_t;

  logic refclk;
  logic rst;
  logic [11:0] obs;

  int   cyc      = 0;
  int   base     = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [11:0] exp_cur = RST_VEC;

  pll_reset_sequencer_if sif();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (16),
    .LOCK_TIMEOUT_CYCLES (100)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .seq    (sif)
  );

  assign obs = {sif.pll_rst, sif.reset_out, sif.ready, sif.timeout_err, sif.relock_count};

  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  function automatic logic [11:0] mk(input logic pr, input logic ro, input logic rdy,
                                     input logic te, input logic [7:0] rc);
    return {pr, ro, rdy, te, rc};
  endfunction

  // Monitor: samples 1 ns after each rising edge; cyc counts edges.
  initial begin : monitor
    logic [11:0] last;
    exp_t        e;
    last = RST_VEC;
    forever begin
      @(posedge refclk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_change at cyc=%0d: required %h at cyc %0d, outputs still %h",
                 cyc, e.vec, e.cyc, obs);
      end
      if (obs !== last) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change at cyc=%0d: got %h, previous %h", cyc, obs, last);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== obs) begin
            failures++;
            $display("FAIL output_change: got %h at cyc %0d, required %h at cyc %0d",
                     obs, cyc, e.vec, e.cyc);
          end
        end
        last = obs;
      end
    end
  end

  task automatic push_rel(input int rel, input logic [11:0] v);
    exp_t e;
    e.cyc = base + rel;
    e.vec = v;
    exp_q.push_back(e);
    exp_cur = v;
  endtask

  // Return at the falling edge after edge number rel (relative to last reset release).
  task automatic to_edge(input int rel);
    while (cyc < base + rel) @(negedge refclk);
  endtask

  task automatic apply_reset(input bit check_now);
    exp_t e;
    @(negedge refclk);
    sif.locked = 1'b0;
    rst = 1'b1;
    if (check_now) begin
      #1;
      checks++;
      if (obs !== RST_VEC) begin
        failures++;
        $display("FAIL async_reset_immediate: got %h, required %h", obs, RST_VEC);
      end
    end
    if (exp_cur != RST_VEC) begin
      e.cyc = cyc + 1;
      e.vec = RST_VEC;
      exp_q.push_back(e);
      exp_cur = RST_VEC;
    end
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin : stimulus
    int d;
    int n;
    sif.locked = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #4;
    checks++;
    if (obs !== RST_VEC) begin
      failures++;
      $display("FAIL reset_state: got %h, required %h", obs, RST_VEC);
    end
    repeat (2) @(negedge refclk);
    rst = 1'b0;
    base = cyc;

    // Clean bring-up: pll_rst edges 1-4, lock 20 cycles in, RUN 19 edges later.
    push_rel(5,  mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    push_rel(39, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    to_edge(20); sif.locked = 1'b1;
    to_edge(45);

    // Glitch in STABLE at count 10 for 3 cycles: no pll_rst, RUN 19 edges after re-rise.
    apply_reset(1'b0);
    push_rel(5,  mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    push_rel(55, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    to_edge(20); sif.locked = 1'b1;
    to_edge(33); sif.locked = 1'b0;
    to_edge(36); sif.locked = 1'b1;
    to_edge(60);

    // Timeout: re-pulse at edge 105 and every 104 edges, sticky timeout_err.
    apply_reset(1'b0);
    push_rel(5, mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    for (int k = 0; k < 3; k++) begin
      push_rel(105 + 104 * k, mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
      push_rel(109 + 104 * k, mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
    end
    to_edge(330);

    // Lock first seen on the WAIT_LOCK terminal cycle: lock wins, no timeout.
    apply_reset(1'b0);
    push_rel(5,   mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    push_rel(121, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    to_edge(102); sif.locked = 1'b1;
    to_edge(130);

    // Loss of lock in RUN, repeated 300 times: relock_count saturates at 255.
    apply_reset(1'b0);
    push_rel(5,  mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    push_rel(39, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    to_edge(20); sif.locked = 1'b1;
    d = 45;
    for (int i = 0; i < 300; i++) begin
      n = (i + 1 > 255) ? 255 : i + 1;
      push_rel(d + 3,  mk(1'b1, 1'b1, 1'b0, 1'b0, 8'(n)));
      push_rel(d + 7,  mk(1'b0, 1'b1, 1'b0, 1'b0, 8'(n)));
      push_rel(d + 26, mk(1'b0, 1'b0, 1'b1, 1'b0, 8'(n)));
      to_edge(d);     sif.locked = 1'b0;
      to_edge(d + 7); sif.locked = 1'b1;
      d += 30;
    end

    // Lose lock, time out, relock into STABLE, then async reset mid-STABLE.
    push_rel(d + 3,   mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd255));
    push_rel(d + 7,   mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd255));
    push_rel(d + 107, mk(1'b1, 1'b1, 1'b0, 1'b1, 8'd255));
    push_rel(d + 111, mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd255));
    to_edge(d);       sif.locked = 1'b0;
    to_edge(d + 115); sif.locked = 1'b1;
    to_edge(d + 124);
    apply_reset(1'b1);
    push_rel(5, mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    to_edge(12);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected changes outstanding, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
